// File: rtl/spi_responder.sv
// SPI mode-0 responder exposing a byte register file with auto-incrementing
// bursts, plus a local read/write port. SPI pins are oversampled on CLK.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | nSS high, waiting for a transaction to start
// CMD      | shifting in the command byte (R/W flag + start address)
// WDATA    | write burst, each received byte lands at ptr, ptr advances
// RDATA    | read burst, each byte shifts out of tx, ptr advances on reload
// WAIT     | reset seen while nSS low; SPI ignored until nSS goes high
module spi_responder #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              nSS,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [ADDR_W-1:0] LADDR,
    input  logic [7:0]        LWDATA,
    input  logic              LWE,
    output logic [7:0]        LRDATA,
    output logic              WSTROBE,
    output logic [ADDR_W-1:0] WADDR,
    output logic              BUSY
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_WAIT
    } state_t;

    // Synchronizers carry no reset so the reset state can see the live nSS level.
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] nss_sync_q;
    logic                   sck_dly_q;

    always_ff @(posedge CLK) begin
        sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], nSS};
        sck_dly_q   <= sck_sync_q[SYNC_STAGES-1];
    end

    logic sck_s;
    logic mosi_s;
    logic nss_s;
    logic sck_rise;
    logic sck_fall;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign nss_s    = nss_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              miso_q, miso_d;
    logic              wstrobe_q, wstrobe_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        lrdata_q;
    logic              busy_q;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];

    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] cmd_addr;
    logic              byte_done;
    logic              active;
    logic              spi_we;

    assign rx_byte   = {rx_q, mosi_s};
    assign cmd_addr  = rx_byte[ADDR_W-1:0];
    assign byte_done = sck_rise && (cnt_q == 3'd7);
    assign active    = (state_q == ST_CMD) || (state_q == ST_WDATA) || (state_q == ST_RDATA);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        miso_d    = miso_q;
        wstrobe_d = 1'b0;
        waddr_d   = waddr_q;
        spi_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (!nss_s) begin
                    state_d = ST_CMD;
                    cnt_d   = 3'd0;
                end
            end

            ST_WAIT: begin
                miso_d = 1'b0;
                if (nss_s) begin
                    state_d = ST_IDLE;
                end
            end

            ST_CMD, ST_WDATA, ST_RDATA: begin
                if (nss_s) begin
                    // Partial bytes are simply dropped; nothing is committed mid-byte.
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    miso_d  = 1'b0;
                end else begin
                    if (sck_rise) begin
                        rx_d  = rx_byte[6:0];
                        cnt_d = cnt_q + 3'd1;
                    end

                    case (state_q)
                        ST_CMD: begin
                            miso_d = 1'b0;
                            if (byte_done) begin
                                ptr_d = cmd_addr;
                                if (rx_byte[7]) begin
                                    tx_d    = mem_q[cmd_addr];
                                    ptr_d   = cmd_addr + 1'b1;
                                    state_d = ST_RDATA;
                                end else begin
                                    state_d = ST_WDATA;
                                end
                            end
                        end

                        ST_WDATA: begin
                            miso_d = 1'b0;
                            if (byte_done) begin
                                spi_we    = 1'b1;
                                wstrobe_d = 1'b1;
                                waddr_d   = ptr_q;
                                ptr_d     = ptr_q + 1'b1;
                            end
                        end

                        default: begin
                            if (sck_fall) begin
                                miso_d = tx_q[7];
                                tx_d   = {tx_q[6:0], 1'b0};
                            end
                            if (byte_done) begin
                                tx_d  = mem_q[ptr_q];
                                ptr_d = ptr_q + 1'b1;
                            end
                        end
                    endcase
                end
            end

            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // SPI write is applied last so it overrides a local write to the same byte.
    always_comb begin
        mem_d = mem_q;
        if (LWE) begin
            mem_d[LADDR] = LWDATA;
        end
        if (spi_we) begin
            mem_d[ptr_q] = rx_byte;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= nss_s ? ST_IDLE : ST_WAIT;
            cnt_q     <= 3'd0;
            rx_q      <= 7'd0;
            tx_q      <= 8'd0;
            ptr_q     <= '0;
            miso_q    <= 1'b0;
            wstrobe_q <= 1'b0;
            waddr_q   <= '0;
            lrdata_q  <= 8'd0;
            busy_q    <= 1'b0;
            mem_q     <= '{default: 8'h00};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            miso_q    <= miso_d;
            wstrobe_q <= wstrobe_d;
            waddr_q   <= waddr_d;
            lrdata_q  <= mem_q[LADDR];
            busy_q    <= ~nss_s;
            mem_q     <= mem_d;
        end
    end

    assign MISO_OE = active & ~nss_s;
    assign MISO    = miso_q & MISO_OE;
    assign LRDATA  = lrdata_q;
    assign WSTROBE = wstrobe_q;
    assign WADDR   = waddr_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: a bit-banged SPI master, a flat byte-array model
// of the register file, directed vectors/corner sequences and random bursts.
`timescale 1ns/1ps
module tb_spi_responder;

    localparam int ADDR_W      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int CLK_P       = 10;
    localparam int DIR_HALF    = 6 * CLK_P;
    localparam int MIN_HALF    = (SYNC_STAGES + 2) * CLK_P;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              SCK = 1'b0;
    logic              MOSI = 1'b0;
    logic              nSS = 1'b1;
    logic              MISO;
    logic              MISO_OE;
    logic [ADDR_W-1:0] LADDR = '0;
    logic [7:0]        LWDATA = 8'd0;
    logic              LWE = 1'b0;
    logic [7:0]        LRDATA;
    logic              WSTROBE;
    logic [ADDR_W-1:0] WADDR;
    logic              BUSY;

    always #(CLK_P / 2) CLK = ~CLK;

    spi_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK(CLK), .RESET(RESET), .SCK(SCK), .MOSI(MOSI), .nSS(nSS),
        .MISO(MISO), .MISO_OE(MISO_OE), .LADDR(LADDR), .LWDATA(LWDATA),
        .LWE(LWE), .LRDATA(LRDATA), .WSTROBE(WSTROBE), .WADDR(WADDR), .BUSY(BUSY)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]        model_mem [DEPTH];
    logic [ADDR_W-1:0] stb_q [$];
    int miso_hi_cnt = 0;
    int oe_cnt      = 0;
    int busy_cnt    = 0;
    int nss_hi_cnt  = 0;
    int oe_bad_cnt  = 0;

    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    int         collide_idx = -1;

    always @(negedge CLK) begin
        if (WSTROBE) stb_q.push_back(WADDR);
        if (MISO) miso_hi_cnt++;
        if (MISO_OE) oe_cnt++;
        if (BUSY) busy_cnt++;
        nss_hi_cnt = nSS ? nss_hi_cnt + 1 : 0;
        if (MISO_OE && (nss_hi_cnt > SYNC_STAGES + 2)) oe_bad_cnt++;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int half, input int nbits,
                            input bit collide, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            MOSI = tx[i];
            #(half);
            rx[i] = MISO;
            SCK = 1'b1;
            if (collide && i == 0) begin
                // SCK rose just after a negedge; the SPI write lands SYNC_STAGES+1 posedges later
                repeat (SYNC_STAGES) @(negedge CLK);
                LWE = 1'b1;
                @(negedge CLK);
                LWE = 1'b0;
                #(half - (SYNC_STAGES + 1) * CLK_P + 1);
            end else begin
                #(half);
            end
            SCK = 1'b0;
        end
    endtask

    task automatic xact(input int n, input int half, input int off);
        @(posedge CLK);
        #(off);
        nSS = 1'b0;
        #(half);
        for (int k = 0; k < n; k++) spi_byte(tx_buf[k], half, 8, (k == collide_idx), rx_buf[k]);
        #(half);
        nSS = 1'b1;
        #(2 * half);
    endtask

    task automatic lwrite(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge CLK);
        LADDR = a; LWDATA = d; LWE = 1'b1;
        @(negedge CLK);
        LWE = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic lread(input logic [ADDR_W-1:0] a, output logic [7:0] d);
        @(negedge CLK);
        LADDR = a;
        @(negedge CLK);
        d = LRDATA;
    endtask

    task automatic check_mem_all(input string name);
        logic [7:0] d;
        for (int a = 0; a < DEPTH; a++) begin
            lread(4'(a), d);
            chk8($sformatf("%s[%0d]", name, a), d, model_mem[a]);
        end
    endtask

    typedef struct {
        logic [7:0] cmd;
        int         n;
        logic [7:0] d [3];
        logic [7:0] e [3];
        int         nstb;
        int         wa0;
    } vec_t;
    vec_t vecs [8];

    task automatic setv(input int i, input logic [7:0] cmd, input int n,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                        input int nstb, input int wa0);
        vecs[i].cmd = cmd; vecs[i].n = n;
        vecs[i].d[0] = d0; vecs[i].d[1] = d1; vecs[i].d[2] = d2;
        vecs[i].e[0] = e0; vecs[i].e[1] = e1; vecs[i].e[2] = e2;
        vecs[i].nstb = nstb; vecs[i].wa0 = wa0;
    endtask

    initial begin
        vec_t       v;
        logic [7:0] d;
        logic [3:0] ra;
        logic [7:0] rd;
        int         off;

        for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;

        // cmd, nbytes, data, expected MISO bytes, strobes, first WADDR
        setv(0, 8'h03, 2, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 2, 3);
        setv(1, 8'h83, 2, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'h00, 0, 0);
        setv(2, 8'h0E, 3, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3, 14);
        setv(3, 8'h8E, 3, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 0, 0);
        setv(4, 8'h9F, 1, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 0, 0);
        setv(5, 8'h71, 1, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1);
        setv(6, 8'h81, 2, 8'h00, 8'h00, 8'h00, 8'h44, 8'h00, 8'h00, 0, 0);
        setv(7, 8'h84, 1, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 0, 0);

        repeat (5) @(negedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset MISO", int'(MISO), 0);
        chk("reset MISO_OE", int'(MISO_OE), 0);
        chk("reset WSTROBE", int'(WSTROBE), 0);
        chk("reset WADDR", int'(WADDR), 0);
        chk8("reset LRDATA", LRDATA, 8'h00);
        chk("reset BUSY", int'(BUSY), 0);
        check_mem_all("reset mem");

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            tx_buf[0] = v.cmd;
            for (int j = 0; j < v.n; j++) tx_buf[j + 1] = v.d[j];
            stb_q.delete();
            miso_hi_cnt = 0;
            collide_idx = -1;
            xact(v.n + 1, DIR_HALF, 6);
            for (int j = 0; j < v.n; j++) chk8($sformatf("vec%0d rx%0d", i, j), rx_buf[j + 1], v.e[j]);
            chk($sformatf("vec%0d wstrobe count", i), stb_q.size(), v.nstb);
            for (int j = 0; j < stb_q.size(); j++)
                chk($sformatf("vec%0d waddr%0d", i, j), int'(stb_q[j]), (v.wa0 + j) % DEPTH);
            if (!v.cmd[7]) begin
                chk($sformatf("vec%0d miso quiet", i), miso_hi_cnt, 0);
                for (int j = 0; j < v.n; j++) model_mem[(int'(v.cmd[3:0]) + j) % DEPTH] = v.d[j];
            end
        end
        check_mem_all("table mem");

        // read burst wrapping from the top address
        lwrite(4'hF, 8'h81);
        lwrite(4'h0, 8'h7E);
        tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        oe_cnt = 0; busy_cnt = 0;
        xact(3, DIR_HALF, 6);
        chk8("wrap rx0", rx_buf[1], 8'h81);
        chk8("wrap rx1", rx_buf[2], 8'h7E);
        chk("wrap oe seen", int'(oe_cnt > 0), 1);
        chk("wrap busy seen", int'(busy_cnt > 0), 1);
        chk("wrap oe after", int'(MISO_OE), 0);
        chk("wrap busy after", int'(BUSY), 0);

        // aborted byte must not write
        lwrite(4'h2, 8'h5C);
        stb_q.delete();
        @(posedge CLK); #6;
        nSS = 1'b0; #(DIR_HALF);
        spi_byte(8'h02, DIR_HALF, 8, 1'b0, rx_buf[0]);
        spi_byte(8'hFF, DIR_HALF, 5, 1'b0, rx_buf[1]);
        #(DIR_HALF); nSS = 1'b1; #(2 * DIR_HALF);
        chk("abort wstrobe count", stb_q.size(), 0);
        lread(4'h2, d);
        chk8("abort mem2", d, model_mem[2]);
        tx_buf[0] = 8'h82; tx_buf[1] = 8'h00;
        xact(2, DIR_HALF, 6);
        chk8("abort readback", rx_buf[1], 8'h5C);

        // SPI and local write collide in the same cycle
        LADDR = 4'h6; LWDATA = 8'h11;
        tx_buf[0] = 8'h06; tx_buf[1] = 8'h22;
        collide_idx = 1;
        xact(2, DIR_HALF, 6);
        model_mem[6] = 8'h22;
        lread(4'h6, d);
        chk8("collide same addr", d, 8'h22);
        LADDR = 4'h7; LWDATA = 8'h11;
        xact(2, DIR_HALF, 6);
        collide_idx = -1;
        model_mem[7] = 8'h11;
        lread(4'h7, d);
        chk8("collide diff addr local", d, 8'h11);
        lread(4'h6, d);
        chk8("collide diff addr spi", d, 8'h22);

        // reset during the second bit of a read data byte
        @(posedge CLK); #6;
        nSS = 1'b0; #(DIR_HALF);
        spi_byte(8'h83, DIR_HALF, 8, 1'b0, rx_buf[0]);
        spi_byte(8'h00, DIR_HALF, 1, 1'b0, rx_buf[1]);
        MOSI = 1'b0; #(DIR_HALF);
        SCK = 1'b1;
        @(negedge CLK); #1 RESET = 1'b1;
        @(negedge CLK); #1 RESET = 1'b0;
        #(DIR_HALF); SCK = 1'b0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
        repeat (2) @(negedge CLK);
        stb_q.delete(); miso_hi_cnt = 0; oe_cnt = 0;
        chk("rst MISO", int'(MISO), 0);
        chk("rst MISO_OE", int'(MISO_OE), 0);
        chk("rst WADDR", int'(WADDR), 0);
        check_mem_all("rst mem");
        #1;
        spi_byte(8'hFF, DIR_HALF, 6, 1'b0, rx_buf[1]);
        spi_byte(8'hFF, DIR_HALF, 8, 1'b0, rx_buf[2]);
        spi_byte(8'hFF, DIR_HALF, 8, 1'b0, rx_buf[3]);
        chk("rst ignored miso", miso_hi_cnt, 0);
        chk("rst ignored oe", oe_cnt, 0);
        chk("rst ignored wstrobe", stb_q.size(), 0);
        #(DIR_HALF); nSS = 1'b1; #(2 * DIR_HALF);
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h33;
        xact(2, DIR_HALF, 6);
        model_mem[1] = 8'h33;
        chk("rst then write wstrobe", stb_q.size(), 1);
        check_mem_all("rst then write mem");

        // random bursts at the minimum SCK phase with random CLK phase
        for (int b = 0; b < 256; b++) begin
            ra = 4'($urandom_range(0, DEPTH - 1));
            rd = 8'($urandom_range(0, 255));
            off = $urandom_range(1, 8);
            if (off >= 5) off++;
            tx_buf[0] = {1'b0, 3'($urandom_range(0, 7)), ra};
            tx_buf[1] = rd;
            xact(2, MIN_HALF, off);
            model_mem[ra] = rd;
            off = $urandom_range(1, 8);
            if (off >= 5) off++;
            tx_buf[0] = {1'b1, 3'($urandom_range(0, 7)), ra};
            tx_buf[1] = 8'h00;
            xact(2, MIN_HALF, off);
            chk8($sformatf("rand%0d readback @%0h", b, ra), rx_buf[1], model_mem[ra]);
        end

        chk("oe while nss high", oe_bad_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
